operand_reader: RTL and testbench
=================================

// Module: operand_reader
// PURPOSE
//  Read-side sequencer for the 16 x 32 general register bank: accepts an operand-fetch request (Ra, optional Rb).
//  Issues one or two reads over the bank's single synchronous read port; returns the operands on a valid/ready handshake.
//  Applies the base-address rule on the read side: with BAout set, Ra = R0 yields zero regardless of R0 contents.
//  Sits between the control unit (request side) and the ALU / address adder (operand side).
// PARAMETERS
//  DATA_WIDTH  32  operand / register width
//  ADDR_WIDTH  4   register index width (16 registers)
// PORTS
//  clock        in   1           system clock; all state updates on the falling edge, same edge as the register bank
//  clear        in   1           synchronous active-high reset, sampled on the falling edge of clock
//  req_valid    in   1           request present
//  req_ready    out  1           reader can accept a request (high only in IDLE)
//  req_ra       in   ADDR_WIDTH  first operand register index
//  req_rb       in   ADDR_WIDTH  second operand register index
//  req_two      in   1           1 = fetch Ra and Rb; 0 = fetch Ra only
//  req_baout    in   1           base-address mode: Ra == 0 reads as zero
//  rf_rd_en     out  1           register bank read strobe
//  rf_rd_addr   out  ADDR_WIDTH  register bank read index
//  rf_rd_data   in   DATA_WIDTH  read data, valid the clock edge after rf_rd_en
//  op_valid     out  1           operands valid
//  op_ready     in   1           consumer takes operands
//  op_a         out  DATA_WIDTH  operand A
//  op_b         out  DATA_WIDTH  operand B (zero when req_two = 0)
//  busy         out  1           state != IDLE
// BEHAVIOUR
//  - Reset (clear = 1 at an edge): state = IDLE; op_a = op_b = 0; op_valid = rf_rd_en = busy = 0; rf_rd_addr = 0.
//    clear wins over every other input; a request in flight is dropped with no partial result.
//  - FSM states: IDLE, ISSUE_A, ISSUE_B, CAP_A, CAP_B, OUT.
//    IDLE: req_ready = 1. On req_valid at an edge, latch ra, rb, two, baout -> ISSUE_A.
//    ISSUE_A: rf_rd_en = 1, rf_rd_addr = ra. Next state: ISSUE_B if two = 1, else CAP_A.
//    ISSUE_B: rf_rd_en = 1, rf_rd_addr = rb. At the edge, op_a <= masked rf_rd_data -> CAP_B.
//    CAP_A: rf_rd_en = 0. At the edge, op_a <= masked rf_rd_data; op_b <= 0 -> OUT.
//    CAP_B: rf_rd_en = 0. At the edge, op_b <= rf_rd_data -> OUT.
//    OUT: op_valid = 1; op_a/op_b held stable. On op_ready at an edge -> IDLE; op_valid falls.
//  - Mask rule: the op_a capture is forced to 0 when latched baout = 1 and ra = 0. The read is still issued.
//    rb is never masked; R0 as Rb returns its stored value.
//  - Latency (request-accept edge = E0): two-operand op_valid high after E3; one-operand after E2.
//    Back-to-back throughput is one request per 4 (two-op) / 3 (one-op) edges, plus the op_ready wait.
//  - Outputs are registered, except req_ready, rf_rd_en, rf_rd_addr and busy, which are decoded from state.
//    rf_rd_addr = 0 outside ISSUE states.
//  - Requests presented while not IDLE are ignored (req_ready = 0); the requester holds them.
//  - op_ready is ignored outside OUT.
//  - Holding op_ready = 0 in OUT stalls indefinitely; no timeout.
// CONFIGURATION
//  OPERAND_FWD_EN defined: adds inputs rf_wr_en (1), rf_wr_addr (ADDR_WIDTH) and rf_wr_data (DATA_WIDTH).
//    At a capture edge, if rf_wr_en = 1 and rf_wr_addr equals the index being captured, the captured value is
//    rf_wr_data instead of rf_rd_data. The mask rule still has priority for op_a.
//  OPERAND_FWD_EN undefined: the ports are absent; captures always use rf_rd_data.
// TESTING
//  1. clear = 1 for 2 edges mid-ISSUE_B -> IDLE next edge, op_valid = 0, op_a = op_b = 0, req_ready = 1.
//  2. ra = 3, rb = 5, two = 1, bank R3 = 0x11, R5 = 0x22 -> rf_rd_addr 3 then 5;
//     op_valid after E3, op_a = 0x11, op_b = 0x22.
//  3. ra = 0, two = 0, baout = 1, R0 = 0xDEADBEEF -> op_a = 0, op_b = 0, op_valid after E2;
//     repeat with baout = 0 -> op_a = 0xDEADBEEF.
//  4. ra = 4, rb = 0, baout = 1, R0 = 0x7 -> op_b = 0x7 (Rb unmasked).
//     Hold op_ready = 0 for 5 edges -> op_valid and operands stable; new req_valid ignored.
//  5. [OPERAND_FWD_EN] ra = 2, R2 = 0x1, rf_wr_en = 1, rf_wr_addr = 2, rf_wr_data = 0x99 at the op_a capture edge
//     -> op_a = 0x99.
//     Same test with the macro undefined -> op_a = 0x1.

Source files
------------

// File: rtl/operand_reader.sv
// Read-side operand sequencer for the 16 x 32 register bank: one or two reads over a single
// synchronous read port, Ra masking in base-address mode. Optional write forwarding: OPERAND_FWD_EN.
module operand_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_ra,
    input  logic [ADDR_WIDTH-1:0] req_rb,
    input  logic                  req_two,
    input  logic                  req_baout,
    output logic                  rf_rd_en,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
`ifdef OPERAND_FWD_EN
    input  logic                  rf_wr_en,
    input  logic [ADDR_WIDTH-1:0] rf_wr_addr,
    input  logic [DATA_WIDTH-1:0] rf_wr_data,
`endif
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_A = 3'd1,
        ISSUE_B = 3'd2,
        CAP_A   = 3'd3,
        CAP_B   = 3'd4,
        OUT     = 3'd5
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   ra_reg, rb_reg;
    logic                    two_reg, baout_reg;
    logic [DATA_WIDTH-1:0]   op_a_reg, op_b_reg;
    logic                    op_valid_reg;
    logic [DATA_WIDTH-1:0]   a_src, b_src, a_cap;

    // Capture sources: the bank's read data, or the same-edge write when it targets the captured index.
`ifdef OPERAND_FWD_EN
    assign a_src = (rf_wr_en && (rf_wr_addr == ra_reg)) ? rf_wr_data : rf_rd_data;
    assign b_src = (rf_wr_en && (rf_wr_addr == rb_reg)) ? rf_wr_data : rf_rd_data;
`else
    assign a_src = rf_rd_data;
    assign b_src = rf_rd_data;
`endif

    // Base-address mode: R0 as Ra reads as zero, overriding any forwarded value.
    assign a_cap = (baout_reg && (ra_reg == '0)) ? '0 : a_src;

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rf_rd_en   = 1'b0;
        rf_rd_addr = '0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ISSUE_A;
            end
            ISSUE_A: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = ra_reg;
                state_next = two_reg ? ISSUE_B : CAP_A;
            end
            ISSUE_B: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = rb_reg;
                state_next = CAP_B;
            end
            CAP_A:   state_next = OUT;
            CAP_B:   state_next = OUT;
            OUT: begin
                if (op_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State shares the bank's falling edge so read data lands exactly one state later.
    always_ff @(negedge clock) begin
        if (clear) begin
            state_reg    <= IDLE;
            ra_reg       <= '0;
            rb_reg       <= '0;
            two_reg      <= 1'b0;
            baout_reg    <= 1'b0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_valid_reg <= (state_next == OUT);
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        ra_reg    <= req_ra;
                        rb_reg    <= req_rb;
                        two_reg   <= req_two;
                        baout_reg <= req_baout;
                    end
                end
                ISSUE_B: op_a_reg <= a_cap;
                CAP_A: begin
                    op_a_reg <= a_cap;
                    op_b_reg <= '0;
                end
                CAP_B:   op_b_reg <= b_src;
                default: ;
            endcase
        end
    end

    assign op_valid = op_valid_reg;
    assign op_a     = op_a_reg;
    assign op_b     = op_b_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_operand_reader.sv
// Table-driven bench for operand_reader with a behavioural falling-edge register bank.
// Inputs are driven and outputs sampled on the rising edge, away from the active falling edge.
module tb_operand_reader;

    logic        clock = 1'b1;
    logic        clear;
    logic        req_valid, req_ready;
    logic [3:0]  req_ra, req_rb;
    logic        req_two, req_baout;
    logic        rf_rd_en;
    logic [3:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b;
    logic        busy;

    logic [31:0] mem [16];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    operand_reader dut (
        .clock      (clock),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ra     (req_ra),
        .req_rb     (req_rb),
        .req_two    (req_two),
        .req_baout  (req_baout),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
`ifdef OPERAND_FWD_EN
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
`endif
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy)
    );

    // Read-first bank: a write on the same edge as a read is not seen by that read.
    always @(negedge clock) begin
        if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
        if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One request from IDLE up to op_valid; checks read strobes, addresses and latency.
    task automatic do_req(input logic [3:0] ra, input logic [3:0] rb, input logic two,
                          input logic baout, input logic fwd);
        int n;
        @(posedge clock);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_ra = ra; req_rb = rb; req_two = two; req_baout = baout;
        @(posedge clock);
        req_valid = 1'b0;
        n = 0;
        while (!op_valid && n < 12) begin
            if (n == 0) begin
                check("issue_a_en", {31'd0, rf_rd_en}, 32'd1);
                check("issue_a_addr", {28'd0, rf_rd_addr}, {28'd0, ra});
            end
            if (n == 1 && two) check("issue_b_addr", {27'd0, rf_rd_en, rf_rd_addr}, {27'd0, 1'b1, rb});
            if (n == 1 && fwd) begin
                rf_wr_en = 1'b1; rf_wr_addr = ra; rf_wr_data = 32'h99;
            end
            if (n == 2) rf_wr_en = 1'b0;
            @(posedge clock);
            n++;
        end
        rf_wr_en = 1'b0;
        check("latency", n, two ? 32'd3 : 32'd2);
    endtask

    task automatic release_op();
        op_ready = 1'b1;
        @(posedge clock);
        op_ready = 1'b0;
        check("valid_drop", {31'd0, op_valid}, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  ra, rb;
        logic        two, baout;
        logic [31:0] ra_val, rb_val;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{4'd3,  4'd5,  1'b1, 1'b0, 32'h11,       32'h22,   32'h11,       32'h22};
        vecs[1] = '{4'd0,  4'd1,  1'b0, 1'b1, 32'hDEADBEEF, 32'h0,    32'h0,        32'h0};
        vecs[2] = '{4'd0,  4'd1,  1'b0, 1'b0, 32'hDEADBEEF, 32'h0,    32'hDEADBEEF, 32'h0};
        vecs[3] = '{4'd4,  4'd0,  1'b1, 1'b1, 32'hAAAA,     32'h7,    32'hAAAA,     32'h7};
        vecs[4] = '{4'd0,  4'd9,  1'b1, 1'b1, 32'h55,       32'h1234, 32'h0,        32'h1234};
        vecs[5] = '{4'd15, 4'd15, 1'b1, 1'b0, 32'hCAFE,     32'hCAFE, 32'hCAFE,     32'hCAFE};
        vecs[6] = '{4'd7,  4'd3,  1'b0, 1'b1, 32'h77,       32'h33,   32'h77,       32'h0};

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        clear = 1'b1; req_valid = 1'b0; req_ra = '0; req_rb = '0; req_two = 1'b0;
        req_baout = 1'b0; op_ready = 1'b0; rf_wr_en = 1'b0; rf_wr_addr = '0; rf_wr_data = '0;
        rf_rd_data = '0;
        repeat (3) @(posedge clock);
        check("rst_valid", {31'd0, op_valid}, 32'd0);
        check("rst_busy", {30'd0, busy, rf_rd_en}, 32'd0);
        check("rst_ops", op_a | op_b, 32'd0);
        check("rst_addr", {28'd0, rf_rd_addr}, 32'd0);
        clear = 1'b0;

        foreach (vecs[i]) begin
            mem[vecs[i].ra] = vecs[i].ra_val;
            if (vecs[i].two) mem[vecs[i].rb] = vecs[i].rb_val;
            do_req(vecs[i].ra, vecs[i].rb, vecs[i].two, vecs[i].baout, 1'b0);
            check($sformatf("v%0d_op_a", i), op_a, vecs[i].exp_a);
            check($sformatf("v%0d_op_b", i), op_b, vecs[i].exp_b);
            $display("vec %0d: ra=%0d rb=%0d two=%0b baout=%0b -> op_a=0x%08h op_b=0x%08h",
                     i, vecs[i].ra, vecs[i].rb, vecs[i].two, vecs[i].baout, op_a, op_b);
            release_op();
        end

        // Stall in OUT: operands held, new requests refused.
        mem[4] = 32'hAAAA; mem[0] = 32'h7;
        do_req(4'd4, 4'd0, 1'b1, 1'b1, 1'b0);
        req_valid = 1'b1; req_ra = 4'd9; req_rb = 4'd9; req_two = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            check("stall_valid", {30'd0, op_valid, req_ready}, 32'd2);
            check("stall_ops", op_a ^ op_b, 32'hAAAA ^ 32'h7);
        end
        req_valid = 1'b0;
        $display("stall: 5 edges held op_a=0x%08h op_b=0x%08h", op_a, op_b);
        release_op();

        // Clear mid-ISSUE_B drops the request and zeroes the operands.
        mem[3] = 32'h11; mem[5] = 32'h22;
        @(posedge clock);
        req_valid = 1'b1; req_ra = 4'd3; req_rb = 4'd5; req_two = 1'b1; req_baout = 1'b0;
        @(posedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        check("pre_clear_addr", {28'd0, rf_rd_addr}, 32'd5);
        clear = 1'b1;
        repeat (2) @(posedge clock);
        clear = 1'b0;
        check("clear_valid", {31'd0, op_valid}, 32'd0);
        check("clear_ops", op_a | op_b, 32'd0);
        check("clear_ready", {30'd0, req_ready, busy}, 32'd2);
        repeat (3) @(posedge clock);
        check("clear_no_result", {31'd0, op_valid}, 32'd0);
        $display("clear: op_valid=%0b op_a=0x%08h req_ready=%0b", op_valid, op_a, req_ready);

        // Write to Ra on the op_a capture edge.
        mem[2] = 32'h1;
        do_req(4'd2, 4'd0, 1'b0, 1'b0, 1'b1);
`ifdef OPERAND_FWD_EN
        check("fwd_op_a", op_a, 32'h99);
`else
        check("fwd_op_a", op_a, 32'h1);
`endif
        $display("fwd: op_a=0x%08h", op_a);
        release_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
